// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 32-point FFT: loads one contiguous frame, times the core flush,
// the sorter start pulse and the sorter result window. Carries no data.

module fft_frame_ctrl #(
  parameter int N        = 32,
  parameter int PIPE_LAT = 31,
  parameter int SORT_LAT = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_start_fft,
  output logic [$clog2(N)-1:0] o_fft_cnt,
  output logic                 o_start_sorting,
  output logic                 o_out_valid,
  output logic                 o_out_last,
  output logic                 o_busy,
  output logic                 o_err,
  input  logic                 i_err_clr,
  output logic [7:0]           o_frame_cnt
);

  localparam int         CW         = $clog2(N);
  localparam logic [7:0] C_LOAD_END = 8'(N - 1);
  localparam logic [7:0] C_SORT     = 8'(PIPE_LAT);
  localparam logic [7:0] C_RUN_END  = 8'(PIPE_LAT + SORT_LAT - 1);
  localparam logic [7:0] C_EMIT_END = 8'(PIPE_LAT + SORT_LAT + N - 1);
  localparam bit         C_NO_RUN   = (PIPE_LAT + SORT_LAT) <= N;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_EMIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_tmr;
  logic [7:0]    w_tmr_nxt;
  logic          w_accept;
  logic          w_abort;

  logic [CW-1:0] r_fft_cnt;
  logic          r_start_sorting;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_busy;
  logic          r_err;
  logic [7:0]    r_frame_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
          w_tmr_nxt   = 8'd1;
        end
      end
      S_LOAD: begin
        // the core has no stall path, so a gap kills the frame
        if (!i_in_valid) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = 8'd0;
        end else begin
          w_tmr_nxt = r_tmr + 8'd1;
          if (r_tmr == C_LOAD_END) begin
            w_state_nxt = C_NO_RUN ? S_EMIT : S_RUN;
          end
        end
      end
      S_RUN: begin
        w_tmr_nxt = r_tmr + 8'd1;
        if (r_tmr == C_RUN_END) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (r_tmr == C_EMIT_END) begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = 8'd0;
        end else begin
          w_tmr_nxt = r_tmr + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tmr   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // Outputs are registered from the next state/timer so they line up with the timer value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fft_cnt       <= '0;
      r_start_sorting <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_last      <= 1'b0;
      r_busy          <= 1'b0;
      r_err           <= 1'b0;
      r_frame_cnt     <= 8'd0;
    end else begin
      r_fft_cnt       <= (w_state_nxt == S_LOAD || w_state_nxt == S_RUN) ? w_tmr_nxt[CW-1:0] : '0;
      r_start_sorting <= (w_state_nxt != S_IDLE) && (w_tmr_nxt == C_SORT);
      r_out_valid     <= (w_state_nxt == S_EMIT);
      r_out_last      <= (w_state_nxt == S_EMIT) && (w_tmr_nxt == C_EMIT_END);
      r_busy          <= (w_state_nxt != S_IDLE);
      if (w_abort) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
      if (r_state == S_EMIT && r_tmr == C_EMIT_END) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign o_in_ready      = (r_state == S_IDLE || r_state == S_LOAD) && !i_rst;
  assign o_start_fft     = w_accept && !i_rst;
  assign o_fft_cnt       = r_fft_cnt;
  // the pulse is registered ahead of time, so a gap in the same cycle must still veto it
  assign o_start_sorting = r_start_sorting && !w_abort;
  assign o_out_valid     = r_out_valid;
  assign o_out_last      = r_out_last;
  assign o_busy          = r_busy;
  assign o_err           = r_err;
  assign o_frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: a frame-offset reference model checks every cycle, plus a
// scenario table and hand sequences for aborts, reset, free-running input and wrap.

module tb_fft_frame_ctrl;

  localparam int N     = 32;
  localparam int PL    = 31;
  localparam int SL    = 32;
  localparam int END_K = PL + SL + N - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       o_in_ready, o_start_fft, o_start_sorting, o_out_valid, o_out_last, o_busy, o_err;
  logic [4:0] o_fft_cnt;
  logic [7:0] o_frame_cnt;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.N(N), .PIPE_LAT(PL), .SORT_LAT(SL)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .o_start_fft(o_start_fft), .o_fft_cnt(o_fft_cnt), .o_start_sorting(o_start_sorting),
    .o_out_valid(o_out_valid), .o_out_last(o_out_last), .o_busy(o_busy), .o_err(o_err),
    .i_err_clr(err_clr), .o_frame_cnt(o_frame_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: whether a frame is in flight and how many cycles since its sample 0
  bit m_act  = 1'b0;
  int m_k    = 0;
  bit m_err  = 1'b0;
  int m_fcnt = 0;

  int q_sf[$], q_ss[$], q_ov[$], q_last[$];
  bit s_sf, s_busy, s_ov, s_err;
  int s_fcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic clearq();
    q_sf.delete(); q_ss.delete(); q_ov.delete(); q_last.delete();
  endtask

  task automatic tick(input bit iv, input bit clr, input bit rs);
    bit e_rdy, e_sf, e_ss, e_ov, e_last, e_busy, abort;
    int e_cnt;
    @(negedge clk);
    in_valid = iv; err_clr = clr; rst = rs;
    #1;
    abort = m_act && (m_k < N) && !iv;
    if (!m_act) begin
      e_rdy = !rs; e_sf = iv && !rs; e_cnt = 0; e_ss = 0; e_ov = 0; e_last = 0; e_busy = 0;
    end else begin
      e_rdy  = (m_k < N) && !rs;
      e_sf   = 0;
      e_cnt  = (m_k < PL + SL) ? (m_k % N) : 0;
      e_ss   = (m_k == PL) && !abort;
      e_ov   = (m_k >= PL + SL);
      e_last = (m_k == END_K);
      e_busy = 1;
    end
    chk("in_ready", o_in_ready, e_rdy);
    chk("start_fft", o_start_fft, e_sf);
    chk("fft_cnt", o_fft_cnt, e_cnt);
    chk("start_sorting", o_start_sorting, e_ss);
    chk("out_valid", o_out_valid, e_ov);
    chk("out_last", o_out_last, e_last);
    chk("busy", o_busy, e_busy);
    chk("err", o_err, m_err);
    chk("frame_cnt", o_frame_cnt, m_fcnt);
    if (o_start_fft === 1'b1)     q_sf.push_back(cyc);
    if (o_start_sorting === 1'b1) q_ss.push_back(cyc);
    if (o_out_valid === 1'b1)     q_ov.push_back(cyc);
    if (o_out_last === 1'b1)      q_last.push_back(cyc);
    s_sf = o_start_fft; s_busy = o_busy; s_ov = o_out_valid; s_err = o_err; s_fcnt = o_frame_cnt;
    if (rs) begin
      m_act = 0; m_err = 0; m_fcnt = 0;
    end else begin
      if (abort) m_err = 1;
      else if (clr) m_err = 0;
      if (!m_act) begin
        if (iv) begin m_act = 1; m_k = 1; end
      end else if (abort) begin
        m_act = 0;
      end else if (m_k == END_K) begin
        m_act = 0; m_fcnt = (m_fcnt + 1) % 256;
      end else begin
        m_k++;
      end
    end
    cyc++;
  endtask

  task automatic run_nominal(input string tag);
    int fc0;
    fc0 = m_fcnt;
    clearq();
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      tick(k < N, 0, 0);
      if (k == 95) begin
        chk({tag, "_busy_r95"}, s_busy, 0);
        chk({tag, "_fcnt_r95"}, s_fcnt, (fc0 + 1) % 256);
      end
    end
    chk({tag, "_sf_r"}, q_sf.size() > 0 ? q_sf[0] : -1, 0);
    chk({tag, "_ss_n"}, q_ss.size(), 1);
    chk({tag, "_ss_r"}, q_ss.size() > 0 ? q_ss[0] : -1, PL);
    chk({tag, "_ov_n"}, q_ov.size(), N);
    chk({tag, "_ov_first"}, q_ov.size() > 0 ? q_ov[0] : -1, PL + SL);
    chk({tag, "_last_n"}, q_last.size(), 1);
    chk({tag, "_last_r"}, q_last.size() > 0 ? q_last[0] : -1, END_K);
  endtask

  typedef struct {
    int drop;   // first offset with in_valid low, -1 for none
    bit clr;    // pulse err_clr before the frame
    int e_ss;
    int e_ov;
    int e_last;
    bit e_err;
    int e_df;
  } scen_t;

  scen_t tbl[7];

  initial begin
    int fc0;
    tbl[0] = '{drop: -1, clr: 0, e_ss: 1, e_ov: 32, e_last: 1, e_err: 0, e_df: 1};
    tbl[1] = '{drop: 10, clr: 0, e_ss: 0, e_ov: 0,  e_last: 0, e_err: 1, e_df: 0};
    tbl[2] = '{drop: -1, clr: 1, e_ss: 1, e_ov: 32, e_last: 1, e_err: 0, e_df: 1};
    tbl[3] = '{drop: 31, clr: 1, e_ss: 0, e_ov: 0,  e_last: 0, e_err: 1, e_df: 0};
    tbl[4] = '{drop: 40, clr: 1, e_ss: 1, e_ov: 32, e_last: 1, e_err: 0, e_df: 1};
    tbl[5] = '{drop: 1,  clr: 0, e_ss: 0, e_ov: 0,  e_last: 0, e_err: 1, e_df: 0};
    tbl[6] = '{drop: 32, clr: 0, e_ss: 1, e_ov: 32, e_last: 1, e_err: 1, e_df: 1};

    // reset values, in_ready low under reset
    for (int i = 0; i < 3; i++) tick(1, 0, 1);
    tick(0, 0, 0);

    run_nominal("single");

    for (int i = 0; i < 7; i++) begin
      tick(0, tbl[i].clr, 0);
      tick(0, 0, 0);
      fc0 = m_fcnt;
      clearq();
      for (int k = 0; k <= END_K + 2; k++) tick((tbl[i].drop < 0) || (k < tbl[i].drop), 0, 0);
      chk($sformatf("tbl%0d_ss", i), q_ss.size(), tbl[i].e_ss);
      chk($sformatf("tbl%0d_ov", i), q_ov.size(), tbl[i].e_ov);
      chk($sformatf("tbl%0d_last", i), q_last.size(), tbl[i].e_last);
      chk($sformatf("tbl%0d_err", i), s_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_fcnt", i), s_fcnt, (fc0 + tbl[i].e_df) % 256);
    end

    // abort at r10, immediate restart at r11
    tick(0, 1, 0);
    fc0 = m_fcnt;
    clearq();
    for (int k = 0; k < 10; k++) tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    chk("restart_sf", s_sf, 1);
    chk("restart_err", s_err, 1);
    chk("restart_busy", s_busy, 0);
    for (int j = 0; j < 100; j++) tick(j < N - 1, 0, 0);
    chk("restart_ss", q_ss.size(), 1);
    chk("restart_last", q_last.size(), 1);
    chk("restart_fcnt", s_fcnt, (fc0 + 1) % 256);

    // free-running input
    tick(0, 0, 1);
    clearq();
    cyc = 0;
    for (int c = 0; c < 400; c++) begin
      tick(1, 0, 0);
      if (c == 380) chk("free_fcnt_380", s_fcnt, 4);
    end
    chk("free_starts", q_sf.size(), 5);
    for (int j = 0; j < 4; j++) chk($sformatf("free_sf%0d", j), q_sf.size() > j ? q_sf[j] : -1, 95 * j);

    // reset during EMIT, then a nominal frame
    tick(0, 0, 1);
    tick(0, 0, 0);
    for (int k = 0; k < 70; k++) tick(k < N, 0, 0);
    tick(0, 0, 1);
    clearq();
    tick(0, 0, 0);
    chk("rst70_busy", s_busy, 0);
    chk("rst70_ov", s_ov, 0);
    chk("rst70_fcnt", s_fcnt, 0);
    for (int k = 0; k < 40; k++) tick(0, 0, 0);
    chk("rst70_quiet", q_ss.size() + q_ov.size() + q_last.size(), 0);
    run_nominal("post_rst");

    // 256 frames wrap the counter
    tick(0, 0, 1);
    clearq();
    for (int c = 0; c < 256 * 95; c++) tick(1, 0, 0);
    tick(0, 0, 0);
    chk("wrap_last_n", q_last.size(), 256);
    chk("wrap_fcnt", s_fcnt, 0);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick($urandom_range(0, 19) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
